s_axi_lite_regs: RTL

- AXI4-Lite responder (slave) fronting a bank of REG_NUM DWIDTH-bit read/write registers.
- Counterpart to the AXI4-Lite initiator test block: it answers that block's write/read-back sequences and is used as a loopback target in simulation and on fabric.
- Register contents are exported flat to user logic, together with per-register write strobes.

---
 rtl/s_axi_lite_regs_pkg.sv | 33 +++
 rtl/s_axi_lite_regs_if.sv | 32 +++
 rtl/s_axi_lite_regs_regfile.sv | 52 +++++
 rtl/s_axi_lite_regs.sv | 139 +++++++++++++
 4 files changed

// File: rtl/s_axi_lite_regs_pkg.sv
// Shared definitions for the AXI4-Lite register responder.
//   DWIDTH      : data/address width of the bus
//   STRB_W      : byte-enable width
//   RESP_*      : AXI response encodings
//   clogb2      : ceil(log2(n)), minimum 1
//   byte_merge  : merges new bytes into an old word under a byte strobe
package s_axi_lite_regs_pkg;

  localparam int DWIDTH = 32;
  localparam int STRB_W = DWIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic logic [DWIDTH-1:0] byte_merge(input logic [DWIDTH-1:0] old_v,
                                                   input logic [DWIDTH-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DWIDTH-1:0] m;
    m = old_v;
    for (int k = 0; k < STRB_W; k++)
      if (strb[k]) m[8*k +: 8] = new_v[8*k +: 8];
    return m;
  endfunction

endpackage

// File: rtl/s_axi_lite_regs_if.sv
// AXI4-Lite bus bundle between an initiator (master) and the register
// responder (slave). Carries the AW, W, B, AR and R channels.
interface s_axi_lite_regs_if import s_axi_lite_regs_pkg::*; ();

  logic              awvalid, awready;
  logic [DWIDTH-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DWIDTH-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [DWIDTH-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/s_axi_lite_regs_regfile.sv
// Register bank: REG_NUM x DWIDTH registers, one byte-strobed write port,
// one combinational read port.
//   clk, xrst   : clock, async active-high reset
//   we/widx     : write enable and register index, wdata/wstrb data and bytes
//   ridx/rdata  : read index and combinational read data
//   regs        : flat register contents, register i at [i*DWIDTH +: DWIDTH]
//   wr_stb      : registered one-cycle pulse, aligned with the updated value
module s_axi_lite_regfile import s_axi_lite_regs_pkg::*; #(
  parameter int REG_NUM = 4,
  parameter int REG_BIT = clogb2(REG_NUM)
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      we,
  input  logic [REG_BIT-1:0]        widx,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic [STRB_W-1:0]         wstrb,
  input  logic [REG_BIT-1:0]        ridx,
  output logic [DWIDTH-1:0]         rdata,
  output logic [REG_NUM*DWIDTH-1:0] regs,
  output logic [REG_NUM-1:0]        wr_stb
);

  logic [DWIDTH-1:0]  regs_q [REG_NUM];
  logic [REG_NUM-1:0] wr_stb_q;
  logic               w_ok, r_ok;

  // Guards indices beyond REG_NUM when REG_NUM is not a power of two.
  assign w_ok = ({1'b0, widx} < (REG_BIT+1)'(REG_NUM));
  assign r_ok = ({1'b0, ridx} < (REG_BIT+1)'(REG_NUM));

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      wr_stb_q <= '0;
    end else begin
      wr_stb_q <= '0;
      if (we && w_ok) begin
        regs_q[widx]   <= byte_merge(regs_q[widx], wdata, wstrb);
        wr_stb_q[widx] <= 1'b1;
      end
    end
  end

  assign rdata  = r_ok ? regs_q[ridx] : '0;
  assign wr_stb = wr_stb_q;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign regs[g*DWIDTH +: DWIDTH] = regs_q[g];
  end

endmodule

// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite responder in front of a bank of REG_NUM read/write registers.
//   clk, xrst : clock, async active-high reset
//   axi       : AXI4-Lite slave modport (AW/W/B/AR/R channels)
//   regs      : flat register contents for user logic
//   wr_stb    : per-register one-cycle write commit pulse
// Optional build macro S_AXI_LITE_SLVERR_EN: out-of-range accesses are
// rejected with SLVERR (write discarded, read returns 0). Without it the
// index wraps modulo 2^REG_BIT and every response is OKAY.
module s_axi_lite_regs import s_axi_lite_regs_pkg::*; #(
  parameter int REG_NUM    = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      xrst,
  s_axi_lite_regs_if.slave          axi,
  output logic [REG_NUM*DWIDTH-1:0] regs,
  output logic [REG_NUM-1:0]        wr_stb
);

  localparam int REG_BIT = clogb2(REG_NUM);

  logic                  awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic                  arready_q, rvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DWIDTH-1:0]     wdata_q, rdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q, rresp_q;

  logic                  commit, wr_en, aw_in_range, ar_in_range;
  logic [REG_BIT-1:0]    widx, ridx;
  logic [DWIDTH-1:0]     rf_rdata, rd_data;
  logic [1:0]            wr_resp, rd_resp;
  logic                  unused_ok;

  // commit cannot coincide with the bvalid clear since it needs !bvalid_q
  assign commit      = aw_held_q && w_held_q && !bvalid_q;
  assign widx        = awaddr_q[REG_BIT+1:2];
  assign ridx        = axi.araddr[REG_BIT+1:2];
  assign aw_in_range = (awaddr_q[ADDR_WIDTH-1:REG_BIT+2] == '0);
  assign ar_in_range = (axi.araddr[ADDR_WIDTH-1:REG_BIT+2] == '0);

`ifdef S_AXI_LITE_SLVERR_EN
  assign wr_en   = commit && aw_in_range;
  assign wr_resp = aw_in_range ? RESP_OKAY : RESP_SLVERR;
  assign rd_data = ar_in_range ? rf_rdata : '0;
  assign rd_resp = ar_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_en   = commit;
  assign wr_resp = RESP_OKAY;
  assign rd_data = rf_rdata;
  assign rd_resp = RESP_OKAY;
`endif

  // Protection bits, byte offset and interconnect-decoded upper address bits
  // carry no meaning here.
  assign unused_ok = ^{axi.awprot, axi.arprot, axi.araddr, awaddr_q[1:0],
                       axi.awaddr[DWIDTH-1:ADDR_WIDTH], aw_in_range, ar_in_range};

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      // Ready is a single-cycle pulse; only one write may be outstanding.
      awready_q <= axi.awvalid && !awready_q && !aw_held_q && !bvalid_q;
      wready_q  <= axi.wvalid && !wready_q && !w_held_q && !bvalid_q;
      if (axi.awvalid && awready_q) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= axi.awaddr[ADDR_WIDTH-1:0];
      end
      if (axi.wvalid && wready_q) begin
        w_held_q <= 1'b1;
        wdata_q  <= axi.wdata;
        wstrb_q  <= axi.wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
      end else if (bvalid_q && axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= axi.arvalid && !arready_q && !rvalid_q;
      // Read port is combinational on the pre-edge contents, so a read that
      // lands on a commit edge returns the old value.
      if (axi.arvalid && arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  s_axi_lite_regfile #(
    .REG_NUM (REG_NUM),
    .REG_BIT (REG_BIT)
  ) u_regfile (
    .clk    (clk),
    .xrst   (xrst),
    .we     (wr_en),
    .widx   (widx),
    .wdata  (wdata_q),
    .wstrb  (wstrb_q),
    .ridx   (ridx),
    .rdata  (rf_rdata),
    .regs   (regs),
    .wr_stb (wr_stb)
  );

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

endmodule
